// File: rtl/bus_mux_fifo_pkg.sv
// -----------------------------------------------------------------------------
// bus_mux_fifo_pkg
//   Shared helpers for the multi-channel bus buffer:
//     - default parameter values
//     - chw(n): channel-index width, at least 1 bit even for a single channel
//     - rr_reset_ptr(n): arbitration pointer reset value. It points at the last
//       channel so that channel 0 wins the first arbitration after reset.
//   The beat struct {data, ch} depends on module parameters, so each module
//   declares it locally as beat_t.
// -----------------------------------------------------------------------------
package bus_mux_fifo_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_DEPTH  = 4;
  localparam int DEFAULT_NUM_CH = 2;

  // A single channel still needs a 1-bit tag, so the plain $clog2 result is
  // not enough here.
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_reset_ptr(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/bus_mux_fifo_ch.sv
// -----------------------------------------------------------------------------
// bus_mux_fifo_ch
//   Single-channel synchronous FIFO with DEPTH entries. DEPTH must be a power
//   of two, so the read and write pointers wrap naturally. The occupancy count
//   is one bit wider than the pointers, which lets it tell full from empty.
//   Ports:
//     clk, rst   clock; synchronous active-high reset
//     push_i     write wdata_i (ignored when full)
//     pop_i      drop the head entry (ignored when empty)
//     wdata_i    write data
//     rdata_o    head entry; valid whenever empty_o is 0
//     empty_o    no entries
//     full_o     DEPTH entries
//     count_o    current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module bus_mux_fifo_ch #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // A push and a pop in the same cycle leave the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order in which blocks run.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset. Its contents are only
  // read behind a non-zero count, and resetting the count invalidates them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bus_mux_fifo.sv
// -----------------------------------------------------------------------------
// bus_mux_fifo
//   Multi-channel bus buffer. NUM_CH independent valid/ready input channels
//   each feed their own DEPTH-entry FIFO. A round-robin arbiter merges the
//   FIFOs into one registered output stream. Each output beat is tagged with
//   its source channel.
//   Ports:
//     clk, rst    clock; synchronous active-high reset
//     in_valid    per-channel beat valid                  [NUM_CH]
//     in_ready    per-channel accept (= !ch_full)         [NUM_CH]
//     in_data     channel c = in_data[c*WIDTH +: WIDTH]   [NUM_CH*WIDTH]
//     out_valid   output register holds a beat
//     out_ready   consumer accept
//     out_data    beat data                               [WIDTH]
//     out_ch      source channel of the beat              [CHW]
//     ch_full     channel FIFO holds DEPTH entries        [NUM_CH]
//   Configuration macro BUS_MUX_FIFO_BYPASS_EN:
//     When defined, a beat pushed into an empty FIFO may load the output
//     register directly at the edge it is pushed, if it wins arbitration
//     (1-cycle latency). When undefined, every beat goes through its FIFO
//     (2-cycle latency).
// -----------------------------------------------------------------------------
module bus_mux_fifo
  import bus_mux_fifo_pkg::*;
#(
  parameter  int WIDTH  = DEFAULT_WIDTH,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  parameter  int NUM_CH = DEFAULT_NUM_CH,
  localparam int CHW    = chw(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CHW-1:0]          out_ch,
  output logic [NUM_CH-1:0]       ch_full
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [CHW-1:0] RR_RESET = CHW'(rr_reset_ptr(NUM_CH));

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CHW-1:0]   ch;
  } beat_t;

  logic [NUM_CH-1:0] fifo_empty, fifo_full;
  logic [NUM_CH-1:0] fifo_push, fifo_pop;
  logic [NUM_CH-1:0] push, cand;
  logic [WIDTH-1:0]  fifo_rdata [NUM_CH];
  logic [AW:0]       fifo_count [NUM_CH];

  beat_t          out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic [CHW-1:0] rr_ptr_q, rr_ptr_d;

  logic             out_free, load;
  logic             win_found, win_bypass;
  logic [CHW-1:0]   win_ch;
  logic [WIDTH-1:0] win_data;

  // ---------------------------------------------------------------------------
  // Per-channel FIFOs
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bus_mux_fifo_ch #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push[c]),
      .pop_i   (fifo_pop[c]),
      .wdata_i (in_data[c*WIDTH +: WIDTH]),
      .rdata_o (fifo_rdata[c]),
      .empty_o (fifo_empty[c]),
      .full_o  (fifo_full[c]),
      .count_o (fifo_count[c])
    );

    assign ch_full[c] = (fifo_count[c] == (AW+1)'(DEPTH));
  end

  // in_ready depends only on registered occupancy. A full FIFO refuses a beat
  // even in a cycle where it pops, so there is no path from out_ready.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign out_free = ~out_valid_q | out_ready;

`ifdef BUS_MUX_FIFO_BYPASS_EN
  // A pushing channel with an empty FIFO competes as if its beat were queued.
  assign cand = ~fifo_empty | push;
`else
  assign cand = ~fifo_empty;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first candidate strictly above the pointer, then wrap
  // to the lowest candidate at or below it.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_found  = 1'b0;
    win_bypass = 1'b0;
    win_ch     = '0;
    win_data   = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!win_found && cand[c] && ((pass == 0) == (c > int'(rr_ptr_q)))) begin
          win_found  = 1'b1;
          win_ch     = CHW'(c);
          // A winning candidate with an empty FIFO can only be a bypassed push.
          win_bypass = fifo_empty[c];
          win_data   = fifo_empty[c] ? in_data[c*WIDTH +: WIDTH] : fifo_rdata[c];
        end
      end
    end
  end

  assign load = out_free & win_found;

  always_comb begin
    fifo_push = '0;
    fifo_pop  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fifo_pop[c]  = load & ~win_bypass & (win_ch == CHW'(c));
      // A bypassed beat goes straight to the output register, so the FIFO is
      // not written.
      fifo_push[c] = push[c] & ~(load & win_bypass & (win_ch == CHW'(c)));
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and arbitration pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d = load | (out_valid_q & ~out_ready);
    out_d       = out_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_d.data = win_data;
      out_d.ch   = win_ch;
      rr_ptr_d   = win_ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rr_ptr_q    <= RR_RESET;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_ch    = out_q.ch;

endmodule

// File: tb/tb_bus_mux_fifo.sv
// -----------------------------------------------------------------------------
// tb_bus_mux_fifo
//   Self-checking bench for bus_mux_fifo. It uses two instances:
//     dut2  NUM_CH=2, DEPTH=4  directed table, hand sequences, random traffic
//     dut1  NUM_CH=1, DEPTH=2  random valid/ready traffic
//   The reference model keeps one queue of accepted beats per channel. FIFO
//   occupancy is derived from those queues, and round-robin fairness is checked
//   over the observed loads.
// -----------------------------------------------------------------------------
module tb_bus_mux_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut2 signals
  logic [1:0]  iv2;
  logic [15:0] id2;
  logic        or2;
  logic [1:0]  rdy2, full2;
  logic        ov2;
  logic [7:0]  od2;
  logic        oc2;

  // dut1 signals
  logic       iv1, rdy1, full1, or1, ov1, oc1;
  logic [7:0] id1, od1;

  bus_mux_fifo #(.WIDTH(8), .DEPTH(4), .NUM_CH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_ch(oc2),
    .ch_full(full2)
  );

  bus_mux_fifo #(.WIDTH(8), .DEPTH(2), .NUM_CH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ch(oc1),
    .ch_full(full1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iv2 = '0; id2 = '0; or2 = 1'b0;
    iv1 = 1'b0; id1 = '0; or1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Directed table: inputs applied for one edge, outputs expected after it.
  typedef struct {
    logic [1:0] iv;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ev;
    logic [7:0] ed;
    logic       ec;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic [1:0] iv, input logic [7:0] d0, input logic [7:0] d1,
                              input logic ev, input logic [7:0] ed, input logic ec);
    vec_t v;
    v.iv = iv; v.d0 = d0; v.d1 = d1; v.ev = ev; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  // Model state
  logic [7:0] q0[$], q1[$], qs[$];
  logic [7:0] got[$];

  initial begin
    int nxt, cyc, stale, wmax;
    logic acc, sent6;
    int occ0, occ1, pocc0, pocc1, w0, w1;
    logic pfree;

    // ---------------- fill table ----------------
    vecs[0]  = mk(2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
`ifdef BUS_MUX_FIFO_BYPASS_EN
    vecs[1]  = mk(2'b10, 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b1);
    vecs[2]  = mk(2'b00, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b1);
    vecs[3]  = mk(2'b00, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b1);
    vecs[4]  = mk(2'b11, 8'h11, 8'h21, 1'b1, 8'h11, 1'b0);
    vecs[5]  = mk(2'b11, 8'h12, 8'h22, 1'b1, 8'h21, 1'b1);
    vecs[6]  = mk(2'b11, 8'h13, 8'h23, 1'b1, 8'h12, 1'b0);
    vecs[7]  = mk(2'b11, 8'h14, 8'h24, 1'b1, 8'h22, 1'b1);
    vecs[8]  = mk(2'b00, 8'h00, 8'h00, 1'b1, 8'h13, 1'b0);
    vecs[9]  = mk(2'b00, 8'h00, 8'h00, 1'b1, 8'h23, 1'b1);
    vecs[10] = mk(2'b00, 8'h00, 8'h00, 1'b1, 8'h14, 1'b0);
    vecs[11] = mk(2'b00, 8'h00, 8'h00, 1'b1, 8'h24, 1'b1);
    vecs[12] = mk(2'b00, 8'h00, 8'h00, 1'b0, 8'h24, 1'b1);
    vecs[13] = mk(2'b00, 8'h00, 8'h00, 1'b0, 8'h24, 1'b1);
`else
    vecs[1]  = mk(2'b10, 8'h00, 8'hA5, 1'b0, 8'h00, 1'b0);
    vecs[2]  = mk(2'b00, 8'h00, 8'h00, 1'b1, 8'hA5, 1'b1);
    vecs[3]  = mk(2'b00, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b1);
    vecs[4]  = mk(2'b11, 8'h11, 8'h21, 1'b0, 8'hA5, 1'b1);
    vecs[5]  = mk(2'b11, 8'h12, 8'h22, 1'b1, 8'h11, 1'b0);
    vecs[6]  = mk(2'b11, 8'h13, 8'h23, 1'b1, 8'h21, 1'b1);
    vecs[7]  = mk(2'b11, 8'h14, 8'h24, 1'b1, 8'h12, 1'b0);
    vecs[8]  = mk(2'b00, 8'h00, 8'h00, 1'b1, 8'h22, 1'b1);
    vecs[9]  = mk(2'b00, 8'h00, 8'h00, 1'b1, 8'h13, 1'b0);
    vecs[10] = mk(2'b00, 8'h00, 8'h00, 1'b1, 8'h23, 1'b1);
    vecs[11] = mk(2'b00, 8'h00, 8'h00, 1'b1, 8'h14, 1'b0);
    vecs[12] = mk(2'b00, 8'h00, 8'h00, 1'b1, 8'h24, 1'b1);
    vecs[13] = mk(2'b00, 8'h00, 8'h00, 1'b0, 8'h24, 1'b1);
`endif

    // ---------------- reset state ----------------
    do_reset();
    check("rst_out_valid", ov2, 0);
    check("rst_out_data", od2, 0);
    check("rst_out_ch", oc2, 0);
    check("rst_in_ready", rdy2, 2'b11);
    check("rst_ch_full", full2, 2'b00);

    // ---------------- single push, then RR alternation ----------------
    or2 = 1'b1;
    for (int i = 0; i < 14; i++) begin
      iv2 = vecs[i].iv;
      id2 = {vecs[i].d1, vecs[i].d0};
      tick();
      check($sformatf("tbl%0d_out_valid", i), ov2, vecs[i].ev);
      check($sformatf("tbl%0d_out_data", i), od2, vecs[i].ed);
      check($sformatf("tbl%0d_out_ch", i), oc2, vecs[i].ec);
      check($sformatf("tbl%0d_in_ready", i), rdy2, 2'b11);
      check($sformatf("tbl%0d_ch_full", i), full2, 2'b00);
    end

    // ---------------- back-pressure fill, push+pop on full ----------------
    do_reset();
    or2 = 1'b0;
    nxt = 1; cyc = 0;
    while (nxt <= 5 && cyc < 20) begin
      iv2 = 2'b01;
      id2 = {8'h00, 8'(nxt)};
      #1;
      acc = rdy2[0];
      tick();
      if (acc) nxt++;
      cyc++;
    end
    check("bp_accepts", nxt, 6);
    check("bp_ch_full", full2, 2'b01);
    check("bp_in_ready", rdy2, 2'b10);
    check("bp_out_valid", ov2, 1);
    check("bp_out_data", od2, 8'd1);
    id2 = {8'h00, 8'd6};
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_hold_ready", rdy2[0], 0);
      check("bp_hold_data", od2, 8'd1);
      tick();
    end
    got.delete();
    or2 = 1'b1;
    #1;
    check("full_pop_ready", rdy2[0], 0);
    if (ov2 && or2) got.push_back(od2);
    tick();
    check("full_pop_ch_full", full2[0], 0);
    check("full_pop_ready_after", rdy2[0], 1);
    sent6 = 1'b0; cyc = 0;
    while (got.size() < 6 && cyc < 30) begin
      iv2 = sent6 ? 2'b00 : 2'b01;
      #1;
      if (iv2[0] && rdy2[0]) sent6 = 1'b1;
      if (ov2 && or2) got.push_back(od2);
      tick();
      cyc++;
    end
    iv2 = 2'b00;
    check("drain_count", got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++)
      check($sformatf("drain_order%0d", i), got[i], 8'(i + 1));

    // ---------------- reset mid-operation ----------------
    do_reset();
    or2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv2 = 2'b01;
      id2 = {8'h00, 8'(8'h31 + k)};
      tick();
    end
    iv2 = 2'b00;
    check("midrst_pre_valid", ov2, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", ov2, 0);
    check("midrst_out_data", od2, 0);
    check("midrst_out_ch", oc2, 0);
    check("midrst_ch_full", full2, 2'b00);
    check("midrst_in_ready", rdy2, 2'b11);
    or2 = 1'b1;
    stale = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (ov2) stale++;
      tick();
    end
    check("midrst_no_stale", stale, 0);

    // ---------------- random traffic, 2 channels ----------------
    do_reset();
    q0.delete(); q1.delete();
    pfree = 1'b0; pocc0 = 0; pocc1 = 0; w0 = 0; w1 = 0;
    for (int n = 0; n < 3000; n++) begin
      iv2 = 2'($urandom);
      id2 = 16'($urandom);
      or2 = ($urandom_range(0, 3) != 0);
      #1;
      // Effects of the previous edge: a load must happen whenever the stage
      // was free and a FIFO held a beat; RR lets nobody wait two loads.
      if (pfree && (pocc0 > 0 || pocc1 > 0)) check("rnd_load_taken", ov2, 1);
      if (pfree && ov2) begin
        if (oc2 == 1'b0) w0 = 0; else if (pocc0 > 0) w0++; else w0 = 0;
        if (oc2 == 1'b1) w1 = 0; else if (pocc1 > 0) w1++; else w1 = 0;
        wmax = (w0 > w1) ? w0 : w1;
        check("rnd_rr_wait", (wmax <= 1), 1);
      end
      occ0 = q0.size() - ((ov2 && oc2 == 1'b0) ? 1 : 0);
      occ1 = q1.size() - ((ov2 && oc2 == 1'b1) ? 1 : 0);
      check("rnd_ch_full", full2, {occ1 == 4, occ0 == 4});
      check("rnd_in_ready", rdy2, {occ1 != 4, occ0 != 4});
      if (ov2) begin
        if ((oc2 ? q1.size() : q0.size()) == 0) check("rnd_unexpected_beat", ov2, 0);
        else check("rnd_out_data", od2, oc2 ? q1[0] : q0[0]);
        if (or2) begin
          if (oc2 && q1.size() > 0) void'(q1.pop_front());
          if (!oc2 && q0.size() > 0) void'(q0.pop_front());
        end
      end
      if (iv2[0] && rdy2[0]) q0.push_back(id2[7:0]);
      if (iv2[1] && rdy2[1]) q1.push_back(id2[15:8]);
      pfree = !ov2 || or2;
      pocc0 = occ0; pocc1 = occ1;
      tick();
    end
    iv2 = 2'b00; or2 = 1'b1;
    cyc = 0;
    while ((q0.size() + q1.size()) > 0 && cyc < 50) begin
      #1;
      if (ov2) begin
        if (oc2 && q1.size() > 0) begin check("rnd_drain_data", od2, q1[0]); void'(q1.pop_front()); end
        else if (!oc2 && q0.size() > 0) begin check("rnd_drain_data", od2, q0[0]); void'(q0.pop_front()); end
        else check("rnd_drain_unexpected", ov2, 0);
      end
      tick();
      cyc++;
    end
    check("rnd_drain_left", q0.size() + q1.size(), 0);

    // ---------------- random traffic, 1 channel, depth 2 ----------------
    do_reset();
    qs.delete();
    for (int n = 0; n < 10000; n++) begin
      iv1 = 1'($urandom);
      id1 = 8'($urandom);
      or1 = 1'($urandom);
      #1;
      occ0 = qs.size() - (ov1 ? 1 : 0);
      check("one_in_ready", rdy1, (occ0 != 2));
      check("one_ch_full", full1, (occ0 == 2));
      if (ov1) begin
        check("one_out_ch", oc1, 0);
        if (qs.size() == 0) check("one_unexpected_beat", ov1, 0);
        else check("one_out_data", od1, qs[0]);
        if (or1 && qs.size() > 0) void'(qs.pop_front());
      end
      if (iv1 && rdy1) qs.push_back(id1);
      tick();
    end
    iv1 = 1'b0; or1 = 1'b1;
    cyc = 0;
    while (qs.size() > 0 && cyc < 20) begin
      #1;
      if (ov1) begin
        check("one_drain_data", od1, qs[0]);
        void'(qs.pop_front());
      end
      tick();
      cyc++;
    end
    check("one_drain_left", qs.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
